mul_share_arb: RTL and testbench
================================

# mul_share_arb

Round-robin arbiter and sequencer that shares one registered 3x3-bit unsigned multiplier between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, latches its operands, and computes the product one cycle later. It then returns the product tagged with the requester index on a single response channel that supports backpressure. It sits between the requester ports and the combinational 3-bit multiplier datapath and owns every access to that datapath.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 3, operand width; the product is 2*AW bits
- IDW, 2, requester-index width; must satisfy 2^IDW >= NREQ

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*AW  operand A; requester i at bits [i*AW +: AW]
- req_b  in  NREQ*AW  operand B, same packing as req_a
- req_ready  out  NREQ  one-hot grant/accept; a request is taken when req_valid[i] & req_ready[i]
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts the product
- rsp_id  out  IDW  index of the requester that owns rsp_p
- rsp_p  out  2*AW  unsigned product a*b
- busy  out  1  high whenever the FSM is not in IDLE
- ops_done  out  8  count of completed response handshakes, wraps 255 -> 0

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE; req_ready = 0.
  - Otherwise pick the winner g: the first set req_valid bit scanning from rr_ptr upward, modulo NREQ.
  - req_ready is combinational in IDLE only: req_ready = (1 << g).
  - On the clock edge: latch op_a and op_b from requester g, set id_q = g, set rr_ptr = (g+1) mod NREQ, go to MUL.
- MUL:
  - Apply op_a and op_b to the multiplier (exact unsigned product, 2*AW bits, no truncation).
  - On the edge: rsp_p <= product, rsp_id <= id_q, rsp_valid <= 1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_p stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, ops_done += 1, go to IDLE.
- req_ready is 0 in MUL and in RESP. No new request is accepted until the FSM is back in IDLE.
- rr_ptr advances only on a grant. With a single active requester, that requester is granted every round.
- A requester must keep req_a and req_b stable while req_valid is high and the request is not yet accepted. Dropping req_valid before acceptance withdraws the request and is legal.
- Requester indices >= NREQ cannot occur; rr_ptr wraps from NREQ-1 to 0.

## Timing
- Reset (asynchronous, rst_n = 0), applied immediately regardless of state:
  - state = IDLE, rr_ptr = 0
  - rsp_valid = 0, rsp_id = 0, rsp_p = 0
  - ops_done = 0, busy = 0
  - req_ready = 0 while rst_n = 0
- Reset mid-operation discards the in-flight operation. No response is produced, and rr_ptr returns to 0.
- Latency: accept in cycle T (IDLE), MUL in T+1, rsp_valid high from T+2.
- Minimum issue interval is 3 cycles: accept at T, response handshake at T+2, IDLE at T+3, next accept at T+3.
- Every response stall cycle (rsp_ready = 0) adds exactly one cycle.
- rsp_ready asserted in the same cycle rsp_valid first rises completes the handshake in that cycle.
- busy = 1 in MUL and RESP.
- rsp_p and rsp_id change only on the MUL -> RESP edge.

## Test plan
- Single product: requester 2 sends a = 7, b = 7 at T. Required: req_ready = 4'b0100 at T; rsp_valid at T+2 with rsp_p = 49 and rsp_id = 2; ops_done = 1 after the handshake.
- Exhaustive datapath: requester 0 sends all 64 (a, b) pairs, rsp_ready held high. Required: rsp_p = a*b for every pair (including 0*5 = 0 and 7*1 = 7); one response every 3 cycles; ops_done = 64.
- Round robin: all four req_valid held high from reset with distinct operands. Required grant order 0, 1, 2, 3, 0, 1, with rsp_id matching each grant.
- Backpressure: rsp_ready = 0 for 5 cycles after a = 5, b = 6 completes. Required: rsp_valid = 1, rsp_p = 30 and rsp_id stable for all 5 cycles; req_ready stays 0; the handshake occurs in the cycle rsp_ready rises.
- Reset mid-operation: assert rst_n = 0 asynchronously while in MUL. Required: rsp_valid, busy and ops_done at 0 immediately; no response after release; the next grant starts from requester 0.
- Counter wrap: complete 256 operations. Required: ops_done reads 255, then 0.

Source files
------------

// File: rtl/mul_share_arb_if.sv
// rtl/mul_share_arb_if.sv - requester and response channels of the shared multiplier
interface mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*AW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [2*AW-1:0]    rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin arbiter sequencing one registered AWxAW multiplier
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mul_share_arb_if.slave      bus,
  output logic                busy,
  output logic [7:0]          ops_done
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [AW-1:0]     op_a_q, op_a_d;
  logic [AW-1:0]     op_b_q, op_b_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [2*AW-1:0]   rsp_p_q, rsp_p_d;
  logic [7:0]        ops_q, ops_d;

  logic              any_req;
  logic [IDW-1:0]    grant_id;
  logic [NREQ-1:0]   req_ready_c;
  logic [2*AW-1:0]   product;
  int                idx;

  // First pending requester at or after rr_q, wrapping at NREQ.
  always_comb begin
    any_req  = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && bus.req_valid[idx]) begin
        any_req  = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

  assign product = (2*AW)'(op_a_q) * (2*AW)'(op_b_q);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    ops_d       = ops_q;
    req_ready_c = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready_c = NREQ'(1) << grant_id;
          op_a_d      = bus.req_a[grant_id*AW +: AW];
          op_b_d      = bus.req_b[grant_id*AW +: AW];
          id_d        = grant_id;
          rr_d        = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
          state_d     = MUL;
        end
      end
      MUL: begin
        rsp_p_d     = product;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_d       = ops_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      ops_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      ops_q       <= ops_d;
    end
  end

  // Grant is combinational, so it must be masked while reset is held.
  assign bus.req_ready = rst_n ? req_ready_c : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;
  assign busy          = (state_q != IDLE);
  assign ops_done      = ops_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - directed self-checking bench for mul_share_arb
module tb_mul_share_arb;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] ops_done;
  int         checks;
  int         errors;
  logic [7:0] exp_cnt;

  mul_share_arb_if #(.NREQ(4), .AW(3), .IDW(2)) bus ();

  mul_share_arb #(.NREQ(4), .AW(3), .IDW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts in an IDLE cycle at the negedge; ends at the negedge of the following IDLE cycle.
  task automatic do_op(input int i, input logic [2:0] a, input logic [2:0] b);
    logic [5:0] p;
    p = 6'(a) * 6'(b);
    bus.req_valid = 4'(1 << i);
    bus.req_a[i*3 +: 3] = a;
    bus.req_b[i*3 +: 3] = b;
    #1;
    chk("grant", 32'(bus.req_ready), 32'(1 << i));
    next_cycle();
    bus.req_valid = '0;
    chk("mul_busy", 32'(busy), 32'd1);
    chk("mul_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mul_req_ready", 32'(bus.req_ready), 32'd0);
    next_cycle();
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_p", 32'(bus.rsp_p), 32'(p));
    chk("rsp_id", 32'(bus.rsp_id), 32'(i));
    next_cycle();
    exp_cnt = exp_cnt + 8'd1;
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("ops_done", 32'(ops_done), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    exp_cnt = '0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = '0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    next_cycle();
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_p", 32'(bus.rsp_p), 32'd0);
    bus.req_valid = 4'b1111;
    #1;
    chk("reset_req_ready_masked", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    do_reset();

    // Single product from requester 2
    do_op(2, 3'd7, 3'd7);
    chk("single_ops_done", 32'(ops_done), 32'd1);

    // Exhaustive datapath from requester 0
    do_reset();
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        do_op(0, 3'(a), 3'(b));
    chk("exhaustive_ops_done", 32'(ops_done), 32'd64);

    // Round robin with all requesters pending from reset
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_a = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.req_b = {3'd6, 3'd5, 3'd4, 3'd3};
    bus.req_valid = 4'b1111;
    #1;
    chk("rr_req_ready_in_reset", 32'(bus.req_ready), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    exp_cnt = '0;
    #1;
    for (int r = 0; r < 6; r++) begin
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << (r % 4)));
      next_cycle();
      chk("rr_mul_busy", 32'(busy), 32'd1);
      next_cycle();
      chk("rr_rsp_id", 32'(bus.rsp_id), 32'(r % 4));
      chk("rr_rsp_p", 32'(bus.rsp_p), 32'(((r % 4) + 1) * ((r % 4) + 3)));
      next_cycle();
      exp_cnt = exp_cnt + 8'd1;
      chk("rr_ops_done", 32'(ops_done), 32'(exp_cnt));
    end
    bus.req_valid = '0;

    // Backpressure on requester 1 while requester 3 waits
    bus.rsp_ready = 1'b0;
    bus.req_a[3 +: 3] = 3'd5;
    bus.req_b[3 +: 3] = 3'd6;
    bus.req_a[9 +: 3] = 3'd2;
    bus.req_b[9 +: 3] = 3'd3;
    bus.req_valid = 4'b0010;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 32'b0010);
    next_cycle();
    bus.req_valid = 4'b1010;
    next_cycle();
    for (int s = 0; s < 5; s++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_p", 32'(bus.rsp_p), 32'd30);
      chk("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_valid_at_ready", 32'(bus.rsp_valid), 32'd1);
    next_cycle();
    exp_cnt = exp_cnt + 8'd1;
    chk("bp_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_ops_done", 32'(ops_done), 32'(exp_cnt));
    bus.req_valid = 4'b1000;
    #1;
    chk("bp_next_grant", 32'(bus.req_ready), 32'b1000);
    next_cycle();
    bus.req_valid = '0;
    next_cycle();
    chk("bp_r3_rsp_p", 32'(bus.rsp_p), 32'd6);
    chk("bp_r3_rsp_id", 32'(bus.rsp_id), 32'd3);
    next_cycle();

    // Asynchronous reset while in MUL
    bus.req_a[6 +: 3] = 3'd3;
    bus.req_b[6 +: 3] = 3'd5;
    bus.req_valid = 4'b0100;
    #1;
    chk("mr_grant", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    #1;
    chk("mr_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ops_done", 32'(ops_done), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    exp_cnt = '0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("mr_rr_restart", 32'(bus.req_ready), 32'b0001);
    do_op(0, 3'd6, 3'd6);

    // Counter wrap
    while (exp_cnt != 8'd255)
      do_op(int'(exp_cnt) % 4, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    chk("wrap_255", 32'(ops_done), 32'd255);
    do_op(1, 3'd7, 3'd1);
    chk("wrap_0", 32'(ops_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
